// File: rtl/ifetch_unit.sv
// Instruction fetch unit: sequences PC-addressed requests to the instruction
// MMU, buffers one returned instruction for decode, and handles redirects
// (including redirects that arrive while a fetch is still outstanding).
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] inst_addr_o,
  output logic        inst_ena_o,
  input  logic [31:0] inst_data_i,
  input  logic        inst_valid_i,
  input  logic        inst_except_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        ready_i,
  output logic [31:0] if_inst_o,
  output logic [31:0] if_pc_o,
  output logic        if_valid_o,
  output logic        if_except_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        if_valid_q, if_valid_d;
  logic        if_except_q, if_except_d;

  logic        load_tgt;
  logic [31:0] tgt;

  // State register and datapath flops, asynchronously reset low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      pend_q      <= '0;
      if_inst_q   <= '0;
      if_pc_q     <= '0;
      if_valid_q  <= 1'b0;
      if_except_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      pend_q      <= pend_d;
      if_inst_q   <= if_inst_d;
      if_pc_q     <= if_pc_d;
      if_valid_q  <= if_valid_d;
      if_except_q <= if_except_d;
    end
  end

  // Next-state and next-datapath computation
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    pend_d      = pend_q;
    if_inst_d   = if_inst_q;
    if_pc_d     = if_pc_q;
    if_valid_d  = if_valid_q;
    if_except_d = if_except_q;
    load_tgt    = 1'b0;
    tgt         = redirect_pc_i;

    unique case (state_q)
      S_IDLE: begin
        // Responses arriving here belong to an abandoned request; ignore them.
        state_d = S_REQ;
        if (redirect_i) load_tgt = 1'b1;
      end
      S_REQ: begin
        if (inst_valid_i) begin
          if (kill_q || redirect_i) begin
            // A same-cycle redirect is newer than any latched target.
            load_tgt = 1'b1;
            tgt      = redirect_i ? redirect_pc_i : pend_q;
            kill_d   = 1'b0;
          end else if (inst_except_i) begin
            if_inst_d   = '0;
            if_pc_d     = pc_q;
            if_valid_d  = 1'b1;
            if_except_d = 1'b1;
            state_d     = S_HOLD;
          end else begin
            if_inst_d   = inst_data_i;
            if_pc_d     = pc_q;
            if_valid_d  = 1'b1;
            if_except_d = 1'b0;
            pc_d        = pc_q + PC_STEP;
            state_d     = S_HOLD;
          end
        end else if (redirect_i) begin
          // Request stays on the bus until the MMU answers; remember the target.
          kill_d = 1'b1;
          pend_d = redirect_pc_i;
        end
      end
      S_HOLD: begin
        if (redirect_i) begin
          load_tgt = 1'b1;
        end else if (if_valid_q && ready_i) begin
          if_valid_d = 1'b0;
          state_d    = if_except_q ? S_HALT : S_REQ;
        end
      end
      S_HALT: begin
        if (redirect_i) load_tgt = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Common redirect handling; a misaligned target becomes an exception slot
    // directly, without ever going to the MMU.
    if (load_tgt) begin
      pc_d       = tgt;
      if_valid_d = 1'b0;
      state_d    = S_REQ;
      if (tgt[1:0] != 2'b00) begin
        state_d     = S_HOLD;
        if_valid_d  = 1'b1;
        if_except_d = 1'b1;
        if_inst_d   = '0;
        if_pc_d     = tgt;
      end
    end
  end

  // Output decode from registered state
  always_comb begin
    inst_ena_o  = (state_q == S_REQ);
    inst_addr_o = pc_q;
    if_inst_o   = if_inst_q;
    if_pc_o     = if_pc_q;
    if_valid_o  = if_valid_q;
    if_except_o = if_except_q;
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for ifetch_unit.
module tb_ifetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] inst_addr_o;
  logic        inst_ena_o;
  logic [31:0] inst_data_i;
  logic        inst_valid_i;
  logic        inst_except_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        ready_i;
  logic [31:0] if_inst_o;
  logic [31:0] if_pc_o;
  logic        if_valid_o;
  logic        if_except_o;

  int checks = 0;
  int errors = 0;

  ifetch_unit #(.RESET_PC(32'hBFC00000), .PC_STEP(32'd4)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_addr_o  (inst_addr_o),
    .inst_ena_o   (inst_ena_o),
    .inst_data_i  (inst_data_i),
    .inst_valid_i (inst_valid_i),
    .inst_except_i(inst_except_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .ready_i      (ready_i),
    .if_inst_o    (if_inst_o),
    .if_pc_o      (if_pc_o),
    .if_valid_o   (if_valid_o),
    .if_except_o  (if_except_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs settle and inputs change 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; inst_data_i = '0; inst_valid_i = 0; inst_except_i = 0;
    redirect_i = 0; redirect_pc_i = '0; ready_i = 0;
    cyc(); cyc();
    checks++; if (inst_ena_o !== 1'b0) begin errors++; $display("FAIL reset_ena got %b exp 0", inst_ena_o); end
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", if_valid_o); end
    checks++; if (if_pc_o !== 32'h0) begin errors++; $display("FAIL reset_if_pc got %h exp 0", if_pc_o); end
    checks++; if (if_inst_o !== 32'h0) begin errors++; $display("FAIL reset_if_inst got %h exp 0", if_inst_o); end
    checks++; if (if_except_o !== 1'b0) begin errors++; $display("FAIL reset_except got %b exp 0", if_except_o); end
    checks++; if (inst_addr_o !== 32'hBFC00000) begin errors++; $display("FAIL reset_addr got %h exp bfc00000", inst_addr_o); end
    rst = 1'b1;
    cyc();
    checks++; if (inst_ena_o !== 1'b1) begin errors++; $display("FAIL first_req_ena got %b exp 1", inst_ena_o); end
  endtask

  task automatic test_basic_fetch();
    for (int i = 0; i < 2; i++) begin
      checks++; if (inst_addr_o !== 32'hBFC00000 || inst_ena_o !== 1'b1) begin
        errors++; $display("FAIL basic_wait addr %h ena %b exp bfc00000/1", inst_addr_o, inst_ena_o); end
      cyc();
    end
    inst_valid_i = 1; inst_data_i = 32'h24080001; ready_i = 1;
    cyc();
    inst_valid_i = 0;
    checks++; if (if_valid_o !== 1'b1 || if_except_o !== 1'b0) begin
      errors++; $display("FAIL basic_valid got v%b e%b exp v1 e0", if_valid_o, if_except_o); end
    checks++; if (if_pc_o !== 32'hBFC00000) begin errors++; $display("FAIL basic_pc got %h exp bfc00000", if_pc_o); end
    checks++; if (if_inst_o !== 32'h24080001) begin errors++; $display("FAIL basic_inst got %h exp 24080001", if_inst_o); end
    checks++; if (inst_ena_o !== 1'b0) begin errors++; $display("FAIL basic_hold_ena got %b exp 0", inst_ena_o); end
    cyc();
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL basic_consumed got %b exp 0", if_valid_o); end
    checks++; if (inst_addr_o !== 32'hBFC00004 || inst_ena_o !== 1'b1) begin
      errors++; $display("FAIL basic_next addr %h ena %b exp bfc00004/1", inst_addr_o, inst_ena_o); end
  endtask

  task automatic test_stall();
    ready_i = 0; inst_valid_i = 1; inst_data_i = 32'h8C220008;
    cyc();
    inst_valid_i = 0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'hBFC00004 || if_inst_o !== 32'h8C220008 || inst_ena_o !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d v%b pc %h inst %h ena %b exp 1/bfc00004/8c220008/0",
                           i, if_valid_o, if_pc_o, if_inst_o, inst_ena_o); end
      cyc();
    end
    ready_i = 1;
    cyc();
    checks++; if (inst_ena_o !== 1'b1 || inst_addr_o !== 32'hBFC00008 || if_valid_o !== 1'b0) begin
      errors++; $display("FAIL stall_release ena %b addr %h v%b exp 1/bfc00008/0", inst_ena_o, inst_addr_o, if_valid_o); end
  endtask

  task automatic test_redirect_kill();
    cyc(); cyc();
    redirect_i = 1; redirect_pc_i = 32'h80002000;
    cyc();
    redirect_pc_i = 32'h80001000;   // second redirect while kill is set: last wins
    cyc();
    redirect_i = 0;
    checks++; if (inst_addr_o !== 32'hBFC00008 || inst_ena_o !== 1'b1) begin
      errors++; $display("FAIL kill_addr_held addr %h ena %b exp bfc00008/1", inst_addr_o, inst_ena_o); end
    cyc();
    inst_valid_i = 1; inst_data_i = 32'hDEADBEEF;
    cyc();
    inst_valid_i = 0;
    checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL kill_drop got %b exp 0", if_valid_o); end
    checks++; if (inst_addr_o !== 32'h80001000 || inst_ena_o !== 1'b1) begin
      errors++; $display("FAIL kill_target addr %h ena %b exp 80001000/1", inst_addr_o, inst_ena_o); end
    inst_valid_i = 1; inst_data_i = 32'h00851020;
    cyc();
    inst_valid_i = 0;
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h80001000 || if_inst_o !== 32'h00851020) begin
      errors++; $display("FAIL kill_refetch v%b pc %h inst %h exp 1/80001000/00851020", if_valid_o, if_pc_o, if_inst_o); end
    cyc();
    // Redirect coinciding with the response: response dropped, target taken now.
    redirect_i = 1; redirect_pc_i = 32'h00400010; inst_valid_i = 1; inst_data_i = 32'h11111111;
    cyc();
    redirect_i = 0; inst_valid_i = 0;
    checks++; if (if_valid_o !== 1'b0 || inst_addr_o !== 32'h00400010 || inst_ena_o !== 1'b1) begin
      errors++; $display("FAIL coincide v%b addr %h ena %b exp 0/00400010/1", if_valid_o, inst_addr_o, inst_ena_o); end
  endtask

  task automatic test_except();
    ready_i = 0; inst_valid_i = 1; inst_except_i = 1; inst_data_i = 32'h12345678;
    cyc();
    inst_valid_i = 0; inst_except_i = 0;
    checks++; if (if_valid_o !== 1'b1 || if_except_o !== 1'b1 || if_pc_o !== 32'h00400010 || if_inst_o !== 32'h0) begin
      errors++; $display("FAIL exc_slot v%b e%b pc %h inst %h exp 1/1/00400010/0", if_valid_o, if_except_o, if_pc_o, if_inst_o); end
    ready_i = 1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      checks++; if (inst_ena_o !== 1'b0 || if_valid_o !== 1'b0 || inst_addr_o !== 32'h00400010) begin
        errors++; $display("FAIL exc_halt%0d ena %b v%b addr %h exp 0/0/00400010", i, inst_ena_o, if_valid_o, inst_addr_o); end
      cyc();
    end
    redirect_i = 1; redirect_pc_i = 32'hBFC00380;
    cyc();
    redirect_i = 0;
    checks++; if (inst_ena_o !== 1'b1 || inst_addr_o !== 32'hBFC00380) begin
      errors++; $display("FAIL exc_vector ena %b addr %h exp 1/bfc00380", inst_ena_o, inst_addr_o); end
  endtask

  task automatic test_misaligned();
    ready_i = 0; inst_valid_i = 1; inst_data_i = 32'h42000018;
    cyc();
    inst_valid_i = 0;
    checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'hBFC00380) begin
      errors++; $display("FAIL mis_pre v%b pc %h exp 1/bfc00380", if_valid_o, if_pc_o); end
    redirect_i = 1; redirect_pc_i = 32'h80000002;
    cyc();
    redirect_i = 0;
    checks++; if (inst_ena_o !== 1'b0 || if_valid_o !== 1'b1 || if_except_o !== 1'b1 ||
                  if_pc_o !== 32'h80000002 || if_inst_o !== 32'h0) begin
      errors++; $display("FAIL mis_slot ena %b v%b e%b pc %h inst %h exp 0/1/1/80000002/0",
                         inst_ena_o, if_valid_o, if_except_o, if_pc_o, if_inst_o); end
    ready_i = 1;
    cyc(); cyc();
    checks++; if (inst_ena_o !== 1'b0 || if_valid_o !== 1'b0) begin
      errors++; $display("FAIL mis_halt ena %b v%b exp 0/0", inst_ena_o, if_valid_o); end
  endtask

  task automatic test_reset_mid();
    redirect_i = 1; redirect_pc_i = 32'h80000100;
    cyc();
    redirect_i = 0;
    checks++; if (inst_ena_o !== 1'b1 || inst_addr_o !== 32'h80000100) begin
      errors++; $display("FAIL mid_req ena %b addr %h exp 1/80000100", inst_ena_o, inst_addr_o); end
    rst = 1'b0;
    #1;
    checks++; if (inst_ena_o !== 1'b0 || inst_addr_o !== 32'hBFC00000) begin
      errors++; $display("FAIL mid_async ena %b addr %h exp 0/bfc00000", inst_ena_o, inst_addr_o); end
    cyc();
    rst = 1'b1; inst_valid_i = 1; inst_data_i = 32'hAAAA5555;
    cyc();
    inst_valid_i = 0;
    checks++; if (if_valid_o !== 1'b0 || inst_ena_o !== 1'b1 || inst_addr_o !== 32'hBFC00000) begin
      errors++; $display("FAIL mid_late v%b ena %b addr %h exp 0/1/bfc00000", if_valid_o, inst_ena_o, inst_addr_o); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect_kill();
    test_except();
    test_misaligned();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
